// File: rtl/imm_encoder.sv
// imm_encoder: finds the rotated-immediate encoding {rot, imm8} of a 32-bit
// constant by testing one even rotation per cycle, smallest rotation first.
// It also reports whether the constant fits a 12-bit sign-extended immediate.
module imm_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] imm12,
   output logic        rot_ok,
   output logic        sext_ok
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] value_q;
   logic [3:0]  rot_q;
   logic [11:0] imm12_q;
   logic        rot_ok_q;
   logic        sext_ok_q;
   logic        out_valid_q;

   logic [63:0] rot_dbl;
   logic [31:0] cand;
   logic        cand_fits;
   logic        sext_calc;

   // Candidate for the current rotation: value ROL (2*r), a pure circular
   // rotation obtained from the upper half of the doubled word.
   always_comb begin
      rot_dbl   = {value_q, value_q} << {rot_q, 1'b0};
      cand      = rot_dbl[63:32];
      cand_fits = (cand[31:8] == 24'd0);
      sext_calc = (&value[31:11]) | ~(|value[31:11]);
   end

   // Ready is a decode of the state, masked while reset is held so the
   // producer never sees a ready during an abort.
   assign in_ready  = (state_q == S_IDLE) && !reset;
   assign out_valid = out_valid_q;
   assign imm12     = imm12_q;
   assign rot_ok    = rot_ok_q;
   assign sext_ok   = sext_ok_q;

   // Control FSM: accept in IDLE, test one rotation per cycle in SEARCH,
   // hold the registered result in DONE until the consumer takes it.
   // NOTE: the reset branch is asynchronous, so asserting reset mid-search
   // drops the state to IDLE at once and the pending result is never shown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         value_q     <= 32'd0;
         rot_q       <= 4'd0;
         imm12_q     <= 12'd0;
         rot_ok_q    <= 1'b0;
         sext_ok_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: all state uses non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  value_q   <= value;
                  sext_ok_q <= sext_calc;
                  rot_q     <= 4'd0;
                  state_q   <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (cand_fits) begin
                  imm12_q     <= {rot_q, cand[7:0]};
                  rot_ok_q    <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (rot_q == 4'd15) begin
                  imm12_q     <= 12'h000;
                  rot_ok_q    <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  rot_q <= rot_q + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
